// File: rtl/trig_series_engine_if.sv
// Request/response bundle for trig_series_engine.
//   start, mode, x_in, thr : request side (driven by the master)
//   busy, done, result,
//   terms_used             : status/result side (driven by the engine)
interface trig_series_engine_if #(
  parameter int W = 16
);
  logic         start;
  logic         mode;
  logic [W-1:0] x_in;
  logic [W-1:0] thr;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   terms_used;

  modport master (
    output start, mode, x_in, thr,
    input  busy, done, result, terms_used
  );

  modport slave (
    input  start, mode, x_in, thr,
    output busy, done, result, terms_used
  );
endinterface

// File: rtl/trig_series_engine.sv
// Fixed-point Taylor-series cos/sin engine.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : trig_series_engine_if.slave
//          start/mode/x_in/thr sampled on acceptance in IDLE;
//          busy high from the cycle after acceptance until DONE exits;
//          done is a one-cycle pulse with result/terms_used updated on it.
// Optional feature: define TRIG_SERIES_SAT_EN to clamp the x2/term products
// at 2^W-1 and the running sum at the signed W-bit limits instead of
// truncating/wrapping.
module trig_series_engine #(
  parameter int W       = 16,
  parameter int FRAC    = 8,
  parameter int N_TERMS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  trig_series_engine_if.slave     bus
);

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_TERM, S_ACC, S_DONE} state_t;

  localparam logic [W-1:0] ONE = W'(1 << FRAC);

  state_t       state_q;
  logic         mode_q;
  logic [W-1:0] x_q, thr_q, x2_q, term_q, sum_q;
  logic [3:0]   k_q, cnt_q;
  logic         busy_q, done_q;
  logic [W-1:0] result_q;
  logic [3:0]   terms_q;

  // Q0.8 series coefficients 1/((2k)(2k-1)) for cos, 1/((2k+1)(2k)) for sin
  logic [7:0] coef;
  always_comb begin
    coef = '0;
    case (k_q)
      4'd1: coef = mode_q ? 8'd42 : 8'd128;
      4'd2: coef = mode_q ? 8'd12 : 8'd21;
      4'd3: coef = mode_q ? 8'd6  : 8'd8;
      4'd4: coef = mode_q ? 8'd3  : 8'd4;
      4'd5: coef = mode_q ? 8'd2  : 8'd2;
      4'd6: coef = mode_q ? 8'd1  : 8'd1;
      4'd7: coef = mode_q ? 8'd1  : 8'd1;
      4'd8: coef = mode_q ? 8'd0  : 8'd1;
      default: coef = '0;
    endcase
  end

  logic [2*W-1:0] sq_full, tx_full;
  logic [W+7:0]   tc_full;
  logic [W-1:0]   x2_d, tm_d, term_d, sum_d;
  logic signed [W+1:0] sum_sx, term_zx, sum_ext;

  assign sq_full = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};
  assign tx_full = {{W{1'b0}}, term_q} * {{W{1'b0}}, x2_q};
  // Second multiply cannot overflow: (term * coef) >> 8 < 2^W.
  assign tc_full = {8'b0, tm_d} * {{W{1'b0}}, coef};
  assign term_d  = tc_full[W+7:8];

  assign sum_sx  = {{2{sum_q[W-1]}}, sum_q};
  assign term_zx = {2'b00, term_q};
  // Odd-k terms carry a negative sign in both series.
  assign sum_ext = k_q[0] ? (sum_sx - term_zx) : (sum_sx + term_zx);

`ifdef TRIG_SERIES_SAT_EN
  localparam logic signed [W+1:0] SUM_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SUM_MIN = {3'b111, {(W-1){1'b0}}};

  assign x2_d = (|sq_full[2*W-1:W+FRAC]) ? '1 : sq_full[W+FRAC-1:FRAC];
  assign tm_d = (|tx_full[2*W-1:W+FRAC]) ? '1 : tx_full[W+FRAC-1:FRAC];

  always_comb begin
    sum_d = sum_ext[W-1:0];
    if (sum_ext > SUM_MAX)      sum_d = {1'b0, {(W-1){1'b1}}};
    else if (sum_ext < SUM_MIN) sum_d = {1'b1, {(W-1){1'b0}}};
  end
`else
  assign x2_d  = sq_full[W+FRAC-1:FRAC];
  assign tm_d  = tx_full[W+FRAC-1:FRAC];
  assign sum_d = sum_ext[W-1:0];
`endif

  logic unused_bits;
  assign unused_bits = ^{sq_full[FRAC-1:0], sq_full[2*W-1:W+FRAC],
                         tx_full[FRAC-1:0], tx_full[2*W-1:W+FRAC],
                         tc_full[7:0], sum_ext[W+1:W]};

  logic       acc_take, last_k;
  logic [W-1:0] sum_acc;
  logic [3:0] cnt_acc;
  assign acc_take = (term_q >= thr_q);
  assign last_k   = (k_q == 4'(N_TERMS));
  assign sum_acc  = acc_take ? sum_d : sum_q;
  assign cnt_acc  = acc_take ? (cnt_q + 4'd1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      x_q      <= '0;
      thr_q    <= '0;
      x2_q     <= '0;
      term_q   <= '0;
      sum_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      terms_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q  <= bus.mode;
            x_q     <= bus.x_in;
            thr_q   <= bus.thr;
            busy_q  <= 1'b1;
            state_q <= S_SQ;
          end
        end
        S_SQ: begin
          x2_q    <= x2_d;
          term_q  <= mode_q ? x_q : ONE;
          sum_q   <= mode_q ? x_q : ONE;
          k_q     <= 4'd1;
          cnt_q   <= '0;
          state_q <= S_TERM;
        end
        S_TERM: begin
          term_q  <= term_d;
          state_q <= S_ACC;
        end
        S_ACC: begin
          sum_q <= sum_acc;
          cnt_q <= cnt_acc;
          // A below-threshold term ends the series without being added.
          if (!acc_take || last_k) begin
            result_q <= sum_acc;
            terms_q  <= cnt_acc;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            k_q     <= k_q + 4'd1;
            state_q <= S_TERM;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.terms_used = terms_q;

endmodule

// File: tb/tb_trig_series_engine.sv
module tb_trig_series_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] thr = 16'd1;
  bit          sel = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  trig_series_engine_if #(.W(16)) bus0 ();
  trig_series_engine_if #(.W(16)) bus1 ();

  assign bus0.start = start;
  assign bus0.mode  = mode;
  assign bus0.x_in  = x_in;
  assign bus0.thr   = thr;
  assign bus1.start = start;
  assign bus1.mode  = mode;
  assign bus1.x_in  = x_in;
  assign bus1.thr   = thr;

  trig_series_engine #(.W(16), .FRAC(8), .N_TERMS(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  trig_series_engine #(.W(16), .FRAC(8), .N_TERMS(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  logic               done_s, busy_s;
  logic signed [15:0] res_s;
  logic [3:0]         terms_s;
  assign done_s  = sel ? bus1.done       : bus0.done;
  assign busy_s  = sel ? bus1.busy       : bus0.busy;
  assign res_s   = sel ? bus1.result     : bus0.result;
  assign terms_s = sel ? bus1.terms_used : bus0.terms_used;

  typedef struct {
    bit sel;
    bit mode;
    int x;
    int thr;
    int res;
    int terms;
    int lat;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Steps until the selected DUT raises done; returns the edge index or -1.
  task automatic wait_done(input int from, output int at);
    at = -1;
    for (int i = from + 1; i <= from + 40; i++) begin
      step();
      if (done_s) begin
        at = i;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!bus0.busy && !bus1.busy) break;
      step();
    end
    chk("idle", int'(bus0.busy | bus1.busy), 0);
  endtask

  task automatic run_vec(input int idx);
    int at;
    sel   = vecs[idx].sel;
    mode  = vecs[idx].mode;
    x_in  = 16'(vecs[idx].x);
    thr   = 16'(vecs[idx].thr);
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("v%0d_busy", idx), int'(busy_s), 1);
    wait_done(0, at);
    chk($sformatf("v%0d_lat", idx), at, vecs[idx].lat);
    chk($sformatf("v%0d_result", idx), int'(res_s), vecs[idx].res);
    chk($sformatf("v%0d_terms", idx), int'(terms_s), vecs[idx].terms);
    step();
    chk($sformatf("v%0d_donepulse", idx), int'(done_s), 0);
    chk($sformatf("v%0d_busyoff", idx), int'(busy_s), 0);
    wait_idle();
  endtask

  initial begin
    int at;
    //          sel mode  x     thr    res     terms lat
    vecs[0] = '{0, 0, 256,  1,     138,    2, 7};
    vecs[1] = '{0, 1, 256,  1,     215,    2, 7};
    vecs[2] = '{0, 0, 0,    1,     256,    0, 3};
    vecs[3] = '{0, 0, 256,  20,    128,    1, 5};
    vecs[4] = '{0, 1, 0,    1,     0,      0, 3};
    vecs[5] = '{0, 0, 512,  1,     -108,   4, 11};
    vecs[6] = '{0, 0, 0,    0,     256,    8, 17};
    vecs[7] = '{0, 1, 256,  65535, 256,    0, 3};
    vecs[8] = '{1, 0, 256,  1,     128,    1, 3};
`ifdef TRIG_SERIES_SAT_EN
    vecs[9] = '{1, 0, 4096, 1,     -32511, 1, 3};
`else
    vecs[9] = '{1, 0, 4096, 1,     256,    0, 3};
`endif

    step();
    step();
    rst = 1'b0;
    chk("rst_busy",   int'(bus0.busy), 0);
    chk("rst_done",   int'(bus0.done), 0);
    chk("rst_result", int'(bus0.result), 0);
    chk("rst_terms",  int'(bus0.terms_used), 0);

    for (int i = 0; i < 10; i++) run_vec(i);

    // start during a run with different inputs, then held through DONE
    sel = 1'b0;
    mode = 1'b0; x_in = 16'd256; thr = 16'd1; start = 1'b1;
    step();                               // edge 0
    start = 1'b0;
    step(); step();                       // edges 1,2
    mode = 1'b1; x_in = 16'd0; thr = 16'd5; start = 1'b1;
    step();                               // edge 3: ignored
    start = 1'b0;
    wait_done(3, at);
    chk("mid_lat", at, 7);
    chk("mid_result", int'(res_s), 138);
    chk("mid_terms", int'(terms_s), 2);
    mode = 1'b0; x_in = 16'd0; thr = 16'd1; start = 1'b1;
    step();                               // edge 8: DONE, ignored
    chk("done_start_busy", int'(busy_s), 0);
    step();                               // edge 9: accepted in IDLE
    start = 1'b0;
    chk("b2b_busy", int'(busy_s), 1);
    wait_done(9, at);
    chk("b2b_lat", at, 12);
    chk("b2b_result", int'(res_s), 256);
    wait_idle();

    // reset in the middle of a run, with start also asserted
    mode = 1'b0; x_in = 16'd256; thr = 16'd1; start = 1'b1;
    step();                               // edge 0
    start = 1'b0;
    step(); step(); step();               // edges 1..3
    rst = 1'b1; start = 1'b1;
    step();                               // edge 4
    chk("abort_busy", int'(busy_s), 0);
    chk("abort_done", int'(done_s), 0);
    chk("abort_result", int'(res_s), 0);
    chk("abort_terms", int'(terms_s), 0);
    rst = 1'b0;
    step();                               // edge 5: accepted
    start = 1'b0;
    chk("restart_busy", int'(busy_s), 1);
    wait_done(5, at);
    chk("restart_lat", at, 12);
    chk("restart_result", int'(res_s), 138);
    wait_idle();

    // reset wins over start in IDLE
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", int'(busy_s), 0);
    step();
    chk("rst_prio_idle", int'(busy_s), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
